// File: rtl/adr_pkg.sv
// Shared definitions for the adr_walk_gen address generator.
//   - Command codes presented on cmd.
//   - Encoding of the raster-walk state machine.
package adr_pkg;

  localparam logic [3:0] CMD_NONE         = 4'd0;
  localparam logic [3:0] CMD_LOAD_BYTE    = 4'd1;
  localparam logic [3:0] CMD_TEMP_TO_MDAR = 4'd2;
  localparam logic [3:0] CMD_FROM_CH      = 4'd3;
  localparam logic [3:0] CMD_TO_CH        = 4'd4;
  localparam logic [3:0] CMD_INC          = 4'd5;
  localparam logic [3:0] CMD_DEC          = 4'd6;
  localparam logic [3:0] CMD_CLEAR        = 4'd7;
  localparam logic [3:0] CMD_WALK         = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } walk_state_e;

endpackage

// File: rtl/adr_walk_ctr.sv
// Row/column counter for the raster walk.
//   clk_i, rst_i      clock and synchronous active-high reset
//   load_i            latch rows_i/cols_i and restart at r=c=0
//   adv_i             advance one element (column fastest)
//   r_nxt_o, c_nxt_o  position the counters move to on adv_i
//   last_o            current position is the final element
module adr_walk_ctr #(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         adv_i,
  input  logic [W-1:0] rows_i,
  input  logic [W-1:0] cols_i,
  output logic [W-1:0] r_nxt_o,
  output logic [W-1:0] c_nxt_o,
  output logic         last_o
);

  logic [W-1:0] rows_q, cols_q, r_q, c_q;
  logic         col_end_s;

  // Extents are never zero while walking, so cols-1 / rows-1 do not underflow.
  assign col_end_s = (c_q == (cols_q - {{(W-1){1'b0}}, 1'b1}));
  assign last_o    = col_end_s && (r_q == (rows_q - {{(W-1){1'b0}}, 1'b1}));

  // Next position: column wraps to 0 and carries into the row.
  always_comb begin
    r_nxt_o = r_q;
    c_nxt_o = c_q + {{(W-1){1'b0}}, 1'b1};
    if (col_end_s) begin
      c_nxt_o = {W{1'b0}};
      r_nxt_o = r_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_nxt_o = r_q;
    end
  end

  // Counter and extent registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rows_q <= {W{1'b0}};
      cols_q <= {W{1'b0}};
      r_q    <= {W{1'b0}};
      c_q    <= {W{1'b0}};
    end else if (load_i) begin
      rows_q <= rows_i;
      cols_q <= cols_i;
      r_q    <= {W{1'b0}};
      c_q    <= {W{1'b0}};
    end else if (adv_i) begin
      r_q <= r_nxt_o;
      c_q <= c_nxt_o;
    end
  end

endmodule

// File: rtl/adr_walk_gen.sv
// Matrix-address generator driving the memory address register (mdar).
// Sources: NCH coordinate channels (g_in/t_in), a byte-loaded staging
// register (temp), INC/DEC/CLEAR, and an optional hardware raster walk.
// Ports:
//   in_Clock, reset        clock, synchronous active-high reset
//   cmd/cmd_valid/cmd_ready command handshake (codes in adr_pkg)
//   ch_sel, din            channel select, byte for LOAD_BYTE
//   g_in, t_in             packed channel coordinates, channel 0 in LSBs
//   tog_inc, tog           orientation toggle request / current flag
//   step_en                memory ready, advances the walk
//   mdar                   memory address
//   ld_g, ld_t, ld_en      coordinate write-back data and one-hot strobe
//   busy, walk_done        walk active / one-cycle completion pulse
// Configuration macro: ADR_WALK_EN compiles in the walk FSM; without it
// WALK decodes as NONE, busy/walk_done stay 0 and cmd_ready is tied to 1.
module adr_walk_gen
  import adr_pkg::*;
#(
  parameter  int COORD_W = 9,
  parameter  int NCH     = 2,
  parameter  int BYTE_W  = 8,
  localparam int ADDR_W  = 2 * COORD_W,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   in_Clock,
  input  logic                   reset,
  input  logic [3:0]             cmd,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [CH_W-1:0]        ch_sel,
  input  logic [BYTE_W-1:0]      din,
  input  logic [NCH*COORD_W-1:0] g_in,
  input  logic [NCH*COORD_W-1:0] t_in,
  input  logic                   tog_inc,
  input  logic                   step_en,
  output logic                   tog,
  output logic [ADDR_W-1:0]      mdar,
  output logic [COORD_W-1:0]     ld_g,
  output logic [COORD_W-1:0]     ld_t,
  output logic [NCH-1:0]         ld_en,
  output logic                   busy,
  output logic                   walk_done
);

  // tog=1 puts t in the upper field.
  function automatic logic [ADDR_W-1:0] pack_f(input logic t_hi,
                                               input logic [COORD_W-1:0] g,
                                               input logic [COORD_W-1:0] t);
    pack_f = t_hi ? {t, g} : {g, t};
  endfunction

  function automatic logic [COORD_W-1:0] unpack_g_f(input logic t_hi,
                                                    input logic [ADDR_W-1:0] a);
    unpack_g_f = t_hi ? a[COORD_W-1:0] : a[ADDR_W-1:COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] unpack_t_f(input logic t_hi,
                                                    input logic [ADDR_W-1:0] a);
    unpack_t_f = t_hi ? a[ADDR_W-1:COORD_W] : a[COORD_W-1:0];
  endfunction

  logic                tog_q, tog_d;
  logic [ADDR_W-1:0]   mdar_q, mdar_d, temp_q, temp_d;
  logic [COORD_W-1:0]  ld_g_q, ld_g_d, ld_t_q, ld_t_d;
  logic [NCH-1:0]      ld_en_q, ld_en_d;
  logic                accept_s, ch_ok_s;
  logic [COORD_W-1:0]  g_sel_s, t_sel_s;

  assign accept_s = cmd_valid && cmd_ready;
  assign ch_ok_s  = (32'(ch_sel) < NCH);
  assign g_sel_s  = COORD_W'(g_in >> (32'(ch_sel) * COORD_W));
  assign t_sel_s  = COORD_W'(t_in >> (32'(ch_sel) * COORD_W));

`ifdef ADR_WALK_EN
  walk_state_e         state_q, state_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                walk_tog_q, walk_tog_d;
  logic [COORD_W-1:0]  start_g_q, start_g_d, start_t_q, start_t_d;
  logic                ctr_load_s, ctr_adv_s, ctr_last_s;
  logic [COORD_W-1:0]  r_nxt_s, c_nxt_s;

  adr_walk_ctr #(.W(COORD_W)) u_ctr (
    .clk_i   (in_Clock),
    .rst_i   (reset),
    .load_i  (ctr_load_s),
    .adv_i   (ctr_adv_s),
    .rows_i  (temp_q[ADDR_W-1:COORD_W]),
    .cols_i  (temp_q[COORD_W-1:0]),
    .r_nxt_o (r_nxt_s),
    .c_nxt_o (c_nxt_s),
    .last_o  (ctr_last_s)
  );

  // DONE already accepts commands, so cmd_ready rises with walk_done.
  assign cmd_ready = (state_q != ST_WALK);
  assign busy      = busy_q;
  assign walk_done = done_q;
`else
  logic unused_step_s;
  assign unused_step_s = step_en;
  assign cmd_ready     = 1'b1;
  assign busy          = 1'b0;
  assign walk_done     = 1'b0;
`endif

  // Next-state: walk progression first, then accepted command decode.
  always_comb begin
    tog_d   = tog_q;
    mdar_d  = mdar_q;
    temp_d  = temp_q;
    ld_g_d  = ld_g_q;
    ld_t_d  = ld_t_q;
    ld_en_d = {NCH{1'b0}};
`ifdef ADR_WALK_EN
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    walk_tog_d = walk_tog_q;
    start_g_d  = start_g_q;
    start_t_d  = start_t_q;
    ctr_load_s = 1'b0;
    ctr_adv_s  = 1'b0;
    case (state_q)
      ST_WALK: begin
        if (step_en && ctr_last_s) begin
          // mdar stays on the final element.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (step_en) begin
          ctr_adv_s = 1'b1;
          mdar_d    = pack_f(walk_tog_q, start_g_q + r_nxt_s, start_t_q + c_nxt_s);
        end else begin
          mdar_d = mdar_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = state_q;
    endcase
`endif
    // cmd_ready is low exactly while busy walking.
    if (tog_inc && cmd_ready) begin
      tog_d = ~tog_q;
    end else begin
      tog_d = tog_q;
    end
    if (accept_s) begin
      case (cmd)
        CMD_LOAD_BYTE:    temp_d = ADDR_W'({temp_q, din});
        CMD_TEMP_TO_MDAR: mdar_d = temp_q;
        CMD_FROM_CH: begin
          if (ch_ok_s) begin
            mdar_d = pack_f(tog_q, g_sel_s, t_sel_s);
          end else begin
            mdar_d = mdar_q;
          end
        end
        CMD_TO_CH: begin
          if (ch_ok_s) begin
            ld_g_d  = unpack_g_f(tog_q, temp_q);
            ld_t_d  = unpack_t_f(tog_q, temp_q);
            ld_en_d = NCH'(1'b1) << ch_sel;
          end else begin
            ld_en_d = {NCH{1'b0}};
          end
        end
        CMD_INC:   mdar_d = mdar_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        CMD_DEC:   mdar_d = mdar_q - {{(ADDR_W-1){1'b0}}, 1'b1};
        CMD_CLEAR: mdar_d = {ADDR_W{1'b0}};
        CMD_WALK: begin
`ifdef ADR_WALK_EN
          if ((temp_q[ADDR_W-1:COORD_W] == {COORD_W{1'b0}}) ||
              (temp_q[COORD_W-1:0] == {COORD_W{1'b0}})) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            // Start point and orientation use the pre-toggle tog.
            state_d    = ST_WALK;
            busy_d     = 1'b1;
            walk_tog_d = tog_q;
            start_g_d  = unpack_g_f(tog_q, mdar_q);
            start_t_d  = unpack_t_f(tog_q, mdar_q);
            ctr_load_s = 1'b1;
          end
`else
          mdar_d = mdar_q;
`endif
        end
        default: mdar_d = mdar_d;
      endcase
    end else begin
      temp_d = temp_q;
    end
  end

  // State registers.
  always_ff @(posedge in_Clock) begin
    if (reset) begin
      tog_q   <= 1'b0;
      mdar_q  <= {ADDR_W{1'b0}};
      temp_q  <= {ADDR_W{1'b0}};
      ld_g_q  <= {COORD_W{1'b0}};
      ld_t_q  <= {COORD_W{1'b0}};
      ld_en_q <= {NCH{1'b0}};
    end else begin
      tog_q   <= tog_d;
      mdar_q  <= mdar_d;
      temp_q  <= temp_d;
      ld_g_q  <= ld_g_d;
      ld_t_q  <= ld_t_d;
      ld_en_q <= ld_en_d;
    end
  end

`ifdef ADR_WALK_EN
  // Walk FSM registers.
  always_ff @(posedge in_Clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      walk_tog_q <= 1'b0;
      start_g_q  <= {COORD_W{1'b0}};
      start_t_q  <= {COORD_W{1'b0}};
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      walk_tog_q <= walk_tog_d;
      start_g_q  <= start_g_d;
      start_t_q  <= start_t_d;
    end
  end
`endif

  assign tog   = tog_q;
  assign mdar  = mdar_q;
  assign ld_g  = ld_g_q;
  assign ld_t  = ld_t_q;
  assign ld_en = ld_en_q;

endmodule

// File: tb/tb_adr_walk_gen.sv
// Directed self-checking bench for adr_walk_gen (COORD_W=9, NCH=2, BYTE_W=8).
module tb_adr_walk_gen;
  import adr_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        ch_sel;
  logic [7:0]  din;
  logic [17:0] g_in, t_in;
  logic        tog_inc, step_en, tog;
  logic [17:0] mdar;
  logic [8:0]  ld_g, ld_t;
  logic [1:0]  ld_en;
  logic        busy, walk_done;

  int checks = 0;
  int fails  = 0;

  adr_walk_gen #(.COORD_W(9), .NCH(2), .BYTE_W(8)) dut (
    .in_Clock (clk),       .reset     (reset),
    .cmd      (cmd),       .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .ch_sel   (ch_sel),    .din       (din),
    .g_in     (g_in),      .t_in      (t_in),
    .tog_inc  (tog_inc),   .step_en   (step_en),
    .tog      (tog),       .mdar      (mdar),
    .ld_g     (ld_g),      .ld_t      (ld_t),      .ld_en     (ld_en),
    .busy     (busy),      .walk_done (walk_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] c);
    cmd = c; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd = CMD_NONE;
  endtask

  task automatic load_temp(input logic [17:0] v);
    din = {6'd0, v[17:16]}; send(CMD_LOAD_BYTE);
    din = v[15:8];          send(CMD_LOAD_BYTE);
    din = v[7:0];           send(CMD_LOAD_BYTE);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    checks++; if (tog !== 1'b0)        begin fails++; $display("FAIL reset_tog got %0h exp 0", tog); end
    checks++; if (mdar !== 18'h0)      begin fails++; $display("FAIL reset_mdar got %0h exp 0", mdar); end
    checks++; if (ld_g !== 9'h0)       begin fails++; $display("FAIL reset_ld_g got %0h exp 0", ld_g); end
    checks++; if (ld_t !== 9'h0)       begin fails++; $display("FAIL reset_ld_t got %0h exp 0", ld_t); end
    checks++; if (ld_en !== 2'b00)     begin fails++; $display("FAIL reset_ld_en got %0b exp 00", ld_en); end
    checks++; if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (walk_done !== 1'b0)  begin fails++; $display("FAIL reset_walk_done got %0b exp 0", walk_done); end
    checks++; if (cmd_ready !== 1'b1)  begin fails++; $display("FAIL reset_cmd_ready got %0b exp 1", cmd_ready); end
  endtask

  task automatic test_load_byte();
    load_temp(18'h3ABCD);
    checks++; if (mdar !== 18'h0) begin fails++; $display("FAIL load_no_mdar got %0h exp 0", mdar); end
    send(CMD_TEMP_TO_MDAR);
    checks++; if (mdar !== 18'h3ABCD) begin fails++; $display("FAIL temp_to_mdar got %0h exp 3abcd", mdar); end
    // Command without valid must be ignored.
    cmd = CMD_CLEAR; cmd_valid = 1'b0; tick(); cmd = CMD_NONE;
    checks++; if (mdar !== 18'h3ABCD) begin fails++; $display("FAIL no_valid got %0h exp 3abcd", mdar); end
  endtask

  task automatic test_from_ch();
    g_in = {9'h012, 9'h055};
    t_in = {9'h034, 9'h066};
    ch_sel = 1'b1; send(CMD_FROM_CH);
    checks++; if (mdar !== 18'h02434) begin fails++; $display("FAIL from_ch1_tog0 got %0h exp 2434", mdar); end
    tog_inc = 1'b1; tick(); tog_inc = 1'b0;
    checks++; if (tog !== 1'b1) begin fails++; $display("FAIL tog_flip got %0b exp 1", tog); end
    send(CMD_FROM_CH);
    checks++; if (mdar !== 18'h06812) begin fails++; $display("FAIL from_ch1_tog1 got %0h exp 6812", mdar); end
    // Same-cycle toggle: command still sees tog=1.
    ch_sel = 1'b0; tog_inc = 1'b1; send(CMD_FROM_CH); tog_inc = 1'b0;
    checks++; if (mdar !== 18'h0CC55) begin fails++; $display("FAIL from_ch0_old_tog got %0h exp cc55", mdar); end
    checks++; if (tog !== 1'b0) begin fails++; $display("FAIL tog_back got %0b exp 0", tog); end
  endtask

  task automatic test_to_ch();
    load_temp(18'h3ABCD);
    ch_sel = 1'b0; send(CMD_TO_CH);
    checks++; if (ld_g !== 9'h1D5)  begin fails++; $display("FAIL to_ch0_g got %0h exp 1d5", ld_g); end
    checks++; if (ld_t !== 9'h1CD)  begin fails++; $display("FAIL to_ch0_t got %0h exp 1cd", ld_t); end
    checks++; if (ld_en !== 2'b01)  begin fails++; $display("FAIL to_ch0_en got %0b exp 01", ld_en); end
    tick();
    checks++; if (ld_en !== 2'b00)  begin fails++; $display("FAIL ld_en_pulse got %0b exp 00", ld_en); end
    checks++; if (ld_g !== 9'h1D5)  begin fails++; $display("FAIL ld_g_hold got %0h exp 1d5", ld_g); end
    tog_inc = 1'b1; tick(); tog_inc = 1'b0;
    ch_sel = 1'b1; send(CMD_TO_CH);
    checks++; if (ld_g !== 9'h1CD)  begin fails++; $display("FAIL to_ch1_tog1_g got %0h exp 1cd", ld_g); end
    checks++; if (ld_t !== 9'h1D5)  begin fails++; $display("FAIL to_ch1_tog1_t got %0h exp 1d5", ld_t); end
    checks++; if (ld_en !== 2'b10)  begin fails++; $display("FAIL to_ch1_en got %0b exp 10", ld_en); end
    tog_inc = 1'b1; tick(); tog_inc = 1'b0;
  endtask

  task automatic test_inc_dec();
    load_temp(18'h3FFFF);
    send(CMD_TEMP_TO_MDAR);
    send(CMD_INC);
    checks++; if (mdar !== 18'h00000) begin fails++; $display("FAIL inc_wrap got %0h exp 0", mdar); end
    send(CMD_DEC);
    checks++; if (mdar !== 18'h3FFFF) begin fails++; $display("FAIL dec_wrap got %0h exp 3ffff", mdar); end
    send(CMD_DEC);
    checks++; if (mdar !== 18'h3FFFE) begin fails++; $display("FAIL dec got %0h exp 3fffe", mdar); end
    send(CMD_CLEAR);
    checks++; if (mdar !== 18'h00000) begin fails++; $display("FAIL clear got %0h exp 0", mdar); end
  endtask

`ifdef ADR_WALK_EN
  task automatic test_walk();
    logic [17:0] exp_a [6];
    int pulses;
    exp_a = '{18'h00BFE, 18'h00BFF, 18'h00A00, 18'h00DFE, 18'h00DFF, 18'h00C00};
    apply_reset();
    load_temp(18'h00BFE); send(CMD_TEMP_TO_MDAR);
    load_temp(18'h00403);
    step_en = 1'b1;
    send(CMD_WALK);
    checks++; if (mdar !== exp_a[0]) begin fails++; $display("FAIL walk_start got %0h exp %0h", mdar, exp_a[0]); end
    checks++; if (busy !== 1'b1)     begin fails++; $display("FAIL walk_busy got %0b exp 1", busy); end
    // Commands and toggles offered during the walk must be ignored.
    cmd = CMD_CLEAR; cmd_valid = 1'b1; tog_inc = 1'b1;
    pulses = 0;
    for (int k = 1; k < 6; k++) begin
      checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL walk_ready step %0d got %0b exp 0", k, cmd_ready); end
      tick();
      if (walk_done === 1'b1) pulses++;
      checks++; if (mdar !== exp_a[k]) begin fails++; $display("FAIL walk_addr step %0d got %0h exp %0h", k, mdar, exp_a[k]); end
    end
    cmd_valid = 1'b0; cmd = CMD_NONE; tog_inc = 1'b0;
    tick();
    checks++; if (walk_done !== 1'b1) begin fails++; $display("FAIL walk_done_pulse got %0b exp 1", walk_done); end
    checks++; if (busy !== 1'b0)      begin fails++; $display("FAIL walk_busy_end got %0b exp 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL walk_ready_end got %0b exp 1", cmd_ready); end
    checks++; if (mdar !== 18'h00C00) begin fails++; $display("FAIL walk_last got %0h exp c00", mdar); end
    checks++; if (tog !== 1'b0)       begin fails++; $display("FAIL walk_tog_frozen got %0b exp 0", tog); end
    tick();
    checks++; if (walk_done !== 1'b0) begin fails++; $display("FAIL walk_done_one got %0b exp 0", walk_done); end
    checks++; if (pulses !== 0)       begin fails++; $display("FAIL walk_done_early got %0d exp 0", pulses); end
    step_en = 1'b0;
  endtask

  task automatic test_walk_reset();
    step_en = 1'b1;
    send(CMD_WALK);
    tick();
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy got %0b exp 1", busy); end
    apply_reset();
    checks++; if (busy !== 1'b0)      begin fails++; $display("FAIL wr_busy_clr got %0b exp 0", busy); end
    checks++; if (mdar !== 18'h0)     begin fails++; $display("FAIL wr_mdar got %0h exp 0", mdar); end
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL wr_ready got %0b exp 1", cmd_ready); end
    tick(); tick();
    checks++; if (mdar !== 18'h0)     begin fails++; $display("FAIL wr_idle_mdar got %0h exp 0", mdar); end
    step_en = 1'b0;
    // temp is 0 after reset: zero-extent walk.
    send(CMD_INC);
    send(CMD_WALK);
    checks++; if (walk_done !== 1'b1) begin fails++; $display("FAIL zero_done got %0b exp 1", walk_done); end
    checks++; if (mdar !== 18'h1)     begin fails++; $display("FAIL zero_mdar got %0h exp 1", mdar); end
    checks++; if (busy !== 1'b0)      begin fails++; $display("FAIL zero_busy got %0b exp 0", busy); end
    tick();
    checks++; if (walk_done !== 1'b0) begin fails++; $display("FAIL zero_done_one got %0b exp 0", walk_done); end
  endtask
`else
  task automatic test_walk_disabled();
    apply_reset();
    load_temp(18'h00403);
    send(CMD_INC);
    step_en = 1'b1;
    send(CMD_WALK);
    checks++; if (mdar !== 18'h1)     begin fails++; $display("FAIL nowalk_mdar got %0h exp 1", mdar); end
    checks++; if (busy !== 1'b0)      begin fails++; $display("FAIL nowalk_busy got %0b exp 0", busy); end
    checks++; if (walk_done !== 1'b0) begin fails++; $display("FAIL nowalk_done got %0b exp 0", walk_done); end
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL nowalk_ready got %0b exp 1", cmd_ready); end
    send(CMD_INC);
    checks++; if (mdar !== 18'h2)     begin fails++; $display("FAIL nowalk_inc got %0h exp 2", mdar); end
    step_en = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; cmd = CMD_NONE; cmd_valid = 1'b0; ch_sel = 1'b0; din = 8'h00;
    g_in = 18'h0; t_in = 18'h0; tog_inc = 1'b0; step_en = 1'b0;
    test_reset();
    test_load_byte();
    test_from_ch();
    test_to_ch();
    test_inc_dec();
`ifdef ADR_WALK_EN
    test_walk();
    test_walk_reset();
`else
    test_walk_disabled();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
